// File: rtl/branch_predictor.sv
// Dual-slot fetch branch predictor: direct-mapped table of tagged 2-bit counters with targets.
// Optional BP_STATS_EN adds branch/mispredict counters.
module branch_predictor #(
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pcF1,
    input  logic [31:0] pcF2,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        flushD,
    input  logic [31:0] pcD1,
    input  logic [31:0] pcD2,
    input  logic [1:0]  branchD1,
    input  logic [1:0]  branchD2,
    input  logic        pcsrcD1,
    input  logic        pcsrcD2,
    input  logic [31:0] pcbranchD1,
    input  logic [31:0] pcbranchD2,
    output logic [1:0]  predict_takenF,
    output logic [31:0] pcnextF,
    output logic [1:0]  predict_takenD
`ifdef BP_STATS_EN
    ,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
`endif
);
    localparam int unsigned ENTRIES = 1 << IDX_BITS;
    localparam int unsigned TAG_LO  = IDX_BITS + 2;
    localparam int unsigned TAG_HI  = TAG_BITS + IDX_BITS + 1;

    logic                valid     [ENTRIES];
    logic [1:0]          ctrMem    [ENTRIES];
    logic [TAG_BITS-1:0] tagMem    [ENTRIES];
    logic [31:0]         targetMem [ENTRIES];

    function automatic logic [1:0] satCount(input logic [1:0] ctr, input logic taken);
        if (taken) return (ctr == 2'b11) ? 2'b11 : 2'(ctr + 2'd1);
        else       return (ctr == 2'b00) ? 2'b00 : 2'(ctr - 2'd1);
    endfunction

    logic [IDX_BITS-1:0] idxF1, idxF2, idxD1, idxD2;
    logic [TAG_BITS-1:0] tagF1, tagF2, tagD1, tagD2;
    logic                predF1, predF2;

    assign idxF1 = pcF1[TAG_LO-1:2];
    assign idxF2 = pcF2[TAG_LO-1:2];
    assign idxD1 = pcD1[TAG_LO-1:2];
    assign idxD2 = pcD2[TAG_LO-1:2];
    assign tagF1 = pcF1[TAG_HI:TAG_LO];
    assign tagF2 = pcF2[TAG_HI:TAG_LO];
    assign tagD1 = pcD1[TAG_HI:TAG_LO];
    assign tagD2 = pcD2[TAG_HI:TAG_LO];

    // Lookup is suppressed during reset so the reset cycle already falls through to pcF1+8
    assign predF1 = !reset && valid[idxF1] && (tagMem[idxF1] == tagF1) && ctrMem[idxF1][1];
    assign predF2 = !reset && valid[idxF2] && (tagMem[idxF2] == tagF2) && ctrMem[idxF2][1];
    assign predict_takenF = {predF2 && !predF1, predF1};
    assign pcnextF = predF1 ? targetMem[idxF1] :
                     predF2 ? targetMem[idxF2] : pcF1 + 32'd8;

    logic                trainD1, trainD2, hitD1, hitD2, wrD1, wrD2;
    logic [1:0]          newCtr1, newCtr2, baseCtr2;
    logic [31:0]         newTgt1, newTgt2, baseTgt2;
    logic [TAG_BITS-1:0] baseTag2;
    logic                baseValid2;

    assign trainD1 = !stallD && (branchD1 != 2'b00);
    assign trainD2 = !stallD && (branchD2 != 2'b00);

    // Slot2 trains on top of slot1's result when both hit the same index
    always_comb begin
        hitD1      = valid[idxD1] && (tagMem[idxD1] == tagD1);
        wrD1       = trainD1 && (hitD1 || pcsrcD1);
        newCtr1    = hitD1 ? satCount(ctrMem[idxD1], pcsrcD1) : 2'b10;
        newTgt1    = pcsrcD1 ? pcbranchD1 : targetMem[idxD1];
        baseValid2 = valid[idxD2];
        baseTag2   = tagMem[idxD2];
        baseCtr2   = ctrMem[idxD2];
        baseTgt2   = targetMem[idxD2];
        if (wrD1 && (idxD1 == idxD2)) begin
            baseValid2 = 1'b1;
            baseTag2   = tagD1;
            baseCtr2   = newCtr1;
            baseTgt2   = newTgt1;
        end
        hitD2   = baseValid2 && (baseTag2 == tagD2);
        wrD2    = trainD2 && (hitD2 || pcsrcD2);
        newCtr2 = hitD2 ? satCount(baseCtr2, pcsrcD2) : 2'b10;
        newTgt2 = pcsrcD2 ? pcbranchD2 : baseTgt2;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i]  <= 1'b0;
                ctrMem[i] <= 2'b01;
            end
        end else begin
            if (wrD1) begin
                valid[idxD1]  <= 1'b1;
                ctrMem[idxD1] <= newCtr1;
            end
            if (wrD2) begin
                valid[idxD2]  <= 1'b1;
                ctrMem[idxD2] <= newCtr2;
            end
        end
    end

    // Tags and targets are qualified by valid, so they need no reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wrD1) begin
                tagMem[idxD1]    <= tagD1;
                targetMem[idxD1] <= newTgt1;
            end
            if (wrD2) begin
                tagMem[idxD2]    <= tagD2;
                targetMem[idxD2] <= newTgt2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flushD) predict_takenD <= 2'b00;
        else if (!stallD)    predict_takenD <= predict_takenF;
    end

`ifdef BP_STATS_EN
    logic misp1, misp2;
    assign misp1 = trainD1 && (predict_takenD[0] != pcsrcD1);
    assign misp2 = trainD2 && (predict_takenD[1] != pcsrcD2);

    always_ff @(posedge clk) begin
        if (reset) begin
            branch_count     <= 32'd0;
            mispredict_count <= 32'd0;
        end else begin
            branch_count     <= branch_count + 32'(trainD1) + 32'(trainD2);
            mispredict_count <= mispredict_count + 32'(misp1) + 32'(misp2);
        end
    end
`endif

    // stallF and the PC bits outside index/tag do not affect prediction
    logic unusedBits;
    assign unusedBits = ^{stallF, pcF1[1:0], pcF2[1:0], pcD1[1:0], pcD2[1:0],
                          pcF1[31:TAG_HI+1], pcF2[31:TAG_HI+1],
                          pcD1[31:TAG_HI+1], pcD2[31:TAG_HI+1]};
endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default build, stats disabled).
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        reset, stallF, stallD, flushD, pcsrcD1, pcsrcD2;
    logic [31:0] pcF1, pcF2, pcD1, pcD2, pcbranchD1, pcbranchD2, pcnextF;
    logic [1:0]  branchD1, branchD2, predict_takenF, predict_takenD;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk(clk), .reset(reset), .pcF1(pcF1), .pcF2(pcF2), .stallF(stallF),
        .stallD(stallD), .flushD(flushD), .pcD1(pcD1), .pcD2(pcD2),
        .branchD1(branchD1), .branchD2(branchD2), .pcsrcD1(pcsrcD1), .pcsrcD2(pcsrcD2),
        .pcbranchD1(pcbranchD1), .pcbranchD2(pcbranchD2),
        .predict_takenF(predict_takenF), .pcnextF(pcnextF), .predict_takenD(predict_takenD)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setF(input logic [31:0] pc);
        pcF1 = pc;
        pcF2 = pc + 32'd4;
        #1;
    endtask

    // Present one D-stage resolution for a single edge, then idle the D inputs
    task automatic resolve(input logic [1:0] b1, input logic [31:0] p1, input logic s1, input logic [31:0] g1,
                           input logic [1:0] b2, input logic [31:0] p2, input logic s2, input logic [31:0] g2);
        branchD1 = b1; pcD1 = p1; pcsrcD1 = s1; pcbranchD1 = g1;
        branchD2 = b2; pcD2 = p2; pcsrcD2 = s2; pcbranchD2 = g2;
        tick();
        branchD1 = 2'b00; branchD2 = 2'b00; pcsrcD1 = 1'b0; pcsrcD2 = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stallF = 1'b0; stallD = 1'b0; flushD = 1'b0;
        branchD1 = 2'b00; branchD2 = 2'b00; pcsrcD1 = 1'b0; pcsrcD2 = 1'b0;
        pcD1 = 32'h0; pcD2 = 32'h0; pcbranchD1 = 32'h0; pcbranchD2 = 32'h0;
        setF(32'h100);
        tick();
        vectors++; if (predict_takenF !== 2'b00) begin miscompares++; $display("FAIL reset_predF got %b want 00", predict_takenF); end
        vectors++; if (pcnextF !== 32'h108) begin miscompares++; $display("FAIL reset_pcnext got %h want 00000108", pcnextF); end
        vectors++; if (predict_takenD !== 2'b00) begin miscompares++; $display("FAIL reset_predD got %b want 00", predict_takenD); end
        reset = 1'b0;
        tick();
        vectors++; if (predict_takenD !== 2'b00) begin miscompares++; $display("FAIL reset_predD_after got %b want 00", predict_takenD); end
    endtask

    task automatic test_train_taken();
        branchD1 = 2'b01; pcD1 = 32'h100; pcsrcD1 = 1'b1; pcbranchD1 = 32'h200;
        #1;
        vectors++; if (predict_takenF !== 2'b00) begin miscompares++; $display("FAIL train_preupdate got %b want 00", predict_takenF); end
        tick();
        branchD1 = 2'b00; pcsrcD1 = 1'b0;
        #1;
        vectors++; if (predict_takenF !== 2'b01) begin miscompares++; $display("FAIL train_predF got %b want 01", predict_takenF); end
        vectors++; if (pcnextF !== 32'h200) begin miscompares++; $display("FAIL train_pcnext got %h want 00000200", pcnextF); end
        tick();
        vectors++; if (predict_takenD !== 2'b01) begin miscompares++; $display("FAIL train_predD got %b want 01", predict_takenD); end
    endtask

    task automatic test_not_taken();
        resolve(2'b01, 32'h100, 1'b0, 32'hDEAD0, 2'b00, 32'h0, 1'b0, 32'h0); // 10 -> 01
        vectors++; if (predict_takenF !== 2'b00) begin miscompares++; $display("FAIL nt1_predF got %b want 00", predict_takenF); end
        vectors++; if (pcnextF !== 32'h108) begin miscompares++; $display("FAIL nt1_pcnext got %h want 00000108", pcnextF); end
        resolve(2'b11, 32'h100, 1'b0, 32'hDEAD0, 2'b00, 32'h0, 1'b0, 32'h0); // 01 -> 00
        resolve(2'b01, 32'h100, 1'b0, 32'hDEAD0, 2'b00, 32'h0, 1'b0, 32'h0); // 00 stays
        resolve(2'b01, 32'h100, 1'b1, 32'h200, 2'b00, 32'h0, 1'b0, 32'h0);   // 00 -> 01
        vectors++; if (predict_takenF !== 2'b00) begin miscompares++; $display("FAIL floor_predF got %b want 00", predict_takenF); end
        resolve(2'b01, 32'h100, 1'b1, 32'h200, 2'b00, 32'h0, 1'b0, 32'h0);   // 01 -> 10
        vectors++; if (predict_takenF !== 2'b01) begin miscompares++; $display("FAIL retrain_predF got %b want 01", predict_takenF); end
        vectors++; if (pcnextF !== 32'h200) begin miscompares++; $display("FAIL retrain_pcnext got %h want 00000200", pcnextF); end
    endtask

    task automatic test_dual();
        resolve(2'b01, 32'h100, 1'b1, 32'h200, 2'b10, 32'h104, 1'b1, 32'h300); // e0 -> 11, e1 alloc 10
        vectors++; if (predict_takenF !== 2'b01) begin miscompares++; $display("FAIL dual_predF got %b want 01", predict_takenF); end
        vectors++; if (pcnextF !== 32'h200) begin miscompares++; $display("FAIL dual_pcnext got %h want 00000200", pcnextF); end
        setF(32'h0FC);
        vectors++; if (predict_takenF !== 2'b10) begin miscompares++; $display("FAIL slot2_predF got %b want 10", predict_takenF); end
        vectors++; if (pcnextF !== 32'h200) begin miscompares++; $display("FAIL slot2_pcnext got %h want 00000200", pcnextF); end
        setF(32'h104);
        vectors++; if (pcnextF !== 32'h300) begin miscompares++; $display("FAIL slot1b_pcnext got %h want 00000300", pcnextF); end
        setF(32'h100);
        resolve(2'b01, 32'h100, 1'b1, 32'h200, 2'b00, 32'h0, 1'b0, 32'h0);   // 11 stays
        resolve(2'b01, 32'h100, 1'b0, 32'hBAD0, 2'b00, 32'h0, 1'b0, 32'h0);  // 11 -> 10
        vectors++; if (predict_takenF !== 2'b01) begin miscompares++; $display("FAIL sat_predF got %b want 01", predict_takenF); end
        vectors++; if (pcnextF !== 32'h200) begin miscompares++; $display("FAIL nt_keeps_target got %h want 00000200", pcnextF); end
    endtask

    task automatic test_same_index();
        resolve(2'b01, 32'h140, 1'b1, 32'h1400, 2'b01, 32'h240, 1'b1, 32'h2400);
        setF(32'h240);
        vectors++; if (pcnextF !== 32'h2400) begin miscompares++; $display("FAIL sameidx_slot2_wins got %h want 00002400", pcnextF); end
        setF(32'h140);
        vectors++; if (predict_takenF !== 2'b00) begin miscompares++; $display("FAIL sameidx_slot1_evicted got %b want 00", predict_takenF); end
        resolve(2'b01, 32'h180, 1'b1, 32'h700, 2'b01, 32'h180, 1'b1, 32'h710); // alloc 10 then 11
        resolve(2'b01, 32'h180, 1'b0, 32'h0, 2'b00, 32'h0, 1'b0, 32'h0);       // 11 -> 10
        setF(32'h180);
        vectors++; if (predict_takenF !== 2'b01) begin miscompares++; $display("FAIL netdelta_predF got %b want 01", predict_takenF); end
        vectors++; if (pcnextF !== 32'h710) begin miscompares++; $display("FAIL netdelta_pcnext got %h want 00000710", pcnextF); end
    endtask

    task automatic test_stall_flush();
        setF(32'h100);
        vectors++; if (predict_takenF !== 2'b01) begin miscompares++; $display("FAIL slot1_masks_slot2 got %b want 01", predict_takenF); end
        tick();
        vectors++; if (predict_takenD !== 2'b01) begin miscompares++; $display("FAIL capture_predD got %b want 01", predict_takenD); end
        stallD = 1'b1;
        setF(32'h820);
        resolve(2'b10, 32'h820, 1'b1, 32'h900, 2'b01, 32'h824, 1'b1, 32'h904);
        vectors++; if (predict_takenD !== 2'b01) begin miscompares++; $display("FAIL stall_hold_predD got %b want 01", predict_takenD); end
        stallD = 1'b0;
        #1;
        vectors++; if (pcnextF !== 32'h828) begin miscompares++; $display("FAIL stall_no_train got %h want 00000828", pcnextF); end
        stallD = 1'b1; flushD = 1'b1;
        setF(32'h100);
        tick();
        vectors++; if (predict_takenD !== 2'b00) begin miscompares++; $display("FAIL flush_over_stall got %b want 00", predict_takenD); end
        stallD = 1'b0; flushD = 1'b0;
        tick();
        vectors++; if (predict_takenD !== 2'b01) begin miscompares++; $display("FAIL post_flush_capture got %b want 01", predict_takenD); end
    endtask

    task automatic test_alias_wrap();
        setF(32'h100 + (32'd4 << 6));
        vectors++; if (predict_takenF !== 2'b00) begin miscompares++; $display("FAIL alias_predF got %b want 00", predict_takenF); end
        vectors++; if (pcnextF !== 32'h208) begin miscompares++; $display("FAIL alias_pcnext got %h want 00000208", pcnextF); end
        setF(32'hFFFF_FFFC);
        vectors++; if (pcnextF !== 32'h4) begin miscompares++; $display("FAIL wrap_pcnext got %h want 00000004", pcnextF); end
    endtask

    task automatic test_reset_midrun();
        setF(32'h100);
        reset = 1'b1;
        #1;
        vectors++; if (pcnextF !== 32'h108) begin miscompares++; $display("FAIL midreset_cycle_pcnext got %h want 00000108", pcnextF); end
        tick();
        reset = 1'b0;
        #1;
        vectors++; if (predict_takenF !== 2'b00) begin miscompares++; $display("FAIL midreset_history got %b want 00", predict_takenF); end
        vectors++; if (predict_takenD !== 2'b00) begin miscompares++; $display("FAIL midreset_predD got %b want 00", predict_takenD); end
    endtask

    initial begin
        test_reset();
        test_train_taken();
        test_not_taken();
        test_dual();
        test_same_index();
        test_stall_flush();
        test_alias_wrap();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
